// File: rtl/imp_meas_sequencer.sv
// Impedance measurement sequencer: enables the excitation counter, discards
// SettleCycles IP periods, then strobes I/Q samples for AcqCycles periods.
module imp_meas_sequencer #(
  parameter int SW      = 8,
  parameter int AW      = 16,
  parameter int TIMEOUT = 1024,
  parameter int TOW     = 11
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Abort,
  input  logic [SW-1:0] SettleCycles,
  input  logic [AW-1:0] AcqCycles,
  input  logic          IP,
  input  logic          QP,
  output logic          CountEnable,
  output logic          AcqValid,
  output logic          SampleI,
  output logic          SampleQ,
  output logic [AW-1:0] PeriodCount,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACQ, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            ip_q, qp_q;
  logic [SW-1:0]   settle_q, settle_d;
  logic [AW-1:0]   acq_q, acq_d;
  logic [TOW-1:0]  wdog_q, wdog_d;
  logic [AW-1:0]   pc_d, pc_inc;
  logic            ce_d, av_d, si_d, sq_d, busy_d, done_d, err_d;
  logic            ip_rise, qp_rise, wdog_exp, kill;

  assign ip_rise  = IP & ~ip_q;
  assign qp_rise  = QP & ~qp_q;
  assign wdog_exp = (wdog_q == TOW'(TIMEOUT - 1));
  assign pc_inc   = (PeriodCount == {AW{1'b1}}) ? PeriodCount : PeriodCount + AW'(1);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    acq_d    = acq_q;
    wdog_d   = wdog_q;
    pc_d     = PeriodCount;
    ce_d     = CountEnable;
    av_d     = AcqValid;
    busy_d   = Busy;
    err_d    = Error;
    si_d     = 1'b0;
    sq_d     = 1'b0;
    done_d   = 1'b0;
    kill     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort && (AcqCycles != '0)) begin
          settle_d = SettleCycles;
          acq_d    = AcqCycles;
          err_d    = 1'b0;
          ce_d     = 1'b1;
          busy_d   = 1'b1;
          pc_d     = '0;
          wdog_d   = '0;
          if (SettleCycles == '0) begin
            state_d = S_ACQ;
            av_d    = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE, S_ACQ: begin
        if (Abort) begin
          kill = 1'b1;
        end else if (!ip_rise && wdog_exp) begin
          // Reference clock stalled: abandon the measurement and flag it
          kill  = 1'b1;
          err_d = 1'b1;
        end else begin
          wdog_d = ip_rise ? '0 : wdog_q + TOW'(1);
          if (state_q == S_SETTLE) begin
            if (ip_rise) begin
              // The rise that ends settling also opens acquisition period 1
              if (pc_inc == AW'(settle_q)) begin
                state_d = S_ACQ;
                av_d    = 1'b1;
                pc_d    = AW'(1);
                si_d    = 1'b1;
                wdog_d  = '0;
              end else begin
                pc_d = pc_inc;
              end
            end
          end else begin
            if (ip_rise && (PeriodCount == acq_q)) begin
              state_d = S_DONE;
              ce_d    = 1'b0;
              av_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              if (qp_rise && (PeriodCount != '0)) sq_d = 1'b1;
              if (ip_rise) begin
                pc_d = pc_inc;
                si_d = 1'b1;
              end
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        kill = 1'b1;
      end
    endcase

    if (kill) begin
      state_d = S_IDLE;
      ce_d    = 1'b0;
      av_d    = 1'b0;
      busy_d  = 1'b0;
      si_d    = 1'b0;
      sq_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      ip_q        <= 1'b0;
      qp_q        <= 1'b0;
      settle_q    <= '0;
      acq_q       <= '0;
      wdog_q      <= '0;
      PeriodCount <= '0;
      CountEnable <= 1'b0;
      AcqValid    <= 1'b0;
      SampleI     <= 1'b0;
      SampleQ     <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= IP;
      qp_q        <= QP;
      settle_q    <= settle_d;
      acq_q       <= acq_d;
      wdog_q      <= wdog_d;
      PeriodCount <= pc_d;
      CountEnable <= ce_d;
      AcqValid    <= av_d;
      SampleI     <= si_d;
      SampleQ     <= sq_d;
      Busy        <= busy_d;
      Done        <= done_d;
      Error       <= err_d;
    end
  end

endmodule

// File: tb/tb_imp_meas_sequencer.sv
// Bench for imp_meas_sequencer: IDLE vector table, event-list reference model
// for whole measurements, and hand sequences for abort, watchdog and reset.
module tb_imp_meas_sequencer;
  localparam int SW = 8, AW = 16, TIMEOUT = 1024, TOW = 11, MAXC = 400;

  logic          Clk = 1'b0, Resetn = 1'b0, Start = 1'b0, Abort = 1'b0;
  logic          IP = 1'b0, QP = 1'b0;
  logic [SW-1:0] SettleCycles = '0;
  logic [AW-1:0] AcqCycles = '0;
  logic          CountEnable, AcqValid, SampleI, SampleQ, Busy, Done, Error;
  logic [AW-1:0] PeriodCount;
  logic [6:0]    obs;
  int            checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  imp_meas_sequencer #(.SW(SW), .AW(AW), .TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort),
    .SettleCycles(SettleCycles), .AcqCycles(AcqCycles), .IP(IP), .QP(QP),
    .CountEnable(CountEnable), .AcqValid(AcqValid), .SampleI(SampleI),
    .SampleQ(SampleQ), .PeriodCount(PeriodCount), .Busy(Busy), .Done(Done),
    .Error(Error)
  );

  // bit order: CE, AV, Busy, SampleI, SampleQ, Done, Error
  assign obs = {CountEnable, AcqValid, Busy, SampleI, SampleQ, Done, Error};

  typedef struct {
    logic start, abort;
    int   s, a;
    logic ce, av, busy;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Whole measurement against an event-list model: expected strobes are
  // placed on the cycles where the driven IP/QP waveforms rise.
  task automatic run_meas(input int s, input int a, input int p, input int ph,
                          input int abort_k, input bit junk);
    bit         ipv [0:MAXC];
    bit         qpv [0:MAXC];
    int         r[$];
    int         k0, rd, ent, abort_at, last;
    logic [6:0] e;
    for (int n = 0; n <= MAXC; n++) begin
      ipv[n] = (n >= 1) && (((n + ph) % p) < p / 2);
      qpv[n] = (n >= 1) && (((n + ph + p - p / 4) % p) < p / 2);
    end
    for (int n = 1; n <= MAXC; n++) if (ipv[n] && !ipv[n-1]) r.push_back(n);
    k0       = (s == 0) ? 1 : s;
    rd       = r[k0 + a - 1];
    ent      = (s == 0) ? 0 : r[s - 1];
    abort_at = (abort_k > 0) ? r[abort_k - 1] + 2 : -1;
    last     = (abort_at >= 0) ? abort_at + 2 * p : rd + 2;
    for (int n = 0; n <= last; n++) begin
      Abort = (n == abort_at);
      IP    = ipv[n];
      QP    = qpv[n];
      if (n == 0) begin
        Start = 1'b1; SettleCycles = SW'(s); AcqCycles = AW'(a);
      end else if (junk && n <= rd && (abort_at < 0 || n < abort_at)) begin
        Start = 1'($urandom); SettleCycles = SW'($urandom); AcqCycles = AW'($urandom);
      end else begin
        Start = 1'b0;
      end
      tick();
      e = '0;
      if (abort_at < 0 || n < abort_at) begin
        e[6] = n < rd;
        e[5] = (n >= ent) && (n < rd);
        e[4] = n < rd;
        for (int k = k0 - 1; k <= k0 + a - 2; k++) if (r[k] == n) e[3] = 1'b1;
        e[2] = (n >= 1) && qpv[n] && !qpv[n-1] && (n > r[k0 - 1]) && (n < rd);
        e[1] = (n == rd);
      end
      chk($sformatf("meas s%0d a%0d p%0d cyc%0d", s, a, p, n), 32'(obs), 32'(e));
    end
    if (abort_at < 0) chk("final_pcount", 32'(PeriodCount), 32'(a));
    IP = 1'b0; QP = 1'b0; Abort = 1'b0; Start = 1'b0;
    tick();
  endtask

  initial begin
    int s, a, p, ph, ak;
    vecs[0] = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0};  // AcqCycles==0 ignored
    vecs[1] = '{1'b1, 1'b1, 2, 4, 1'b0, 1'b0, 1'b0};  // Start+Abort stays idle
    vecs[2] = '{1'b0, 1'b0, 2, 4, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2, 4, 1'b1, 1'b0, 1'b1};  // into SETTLE
    vecs[4] = '{1'b1, 1'b0, 0, 3, 1'b1, 1'b1, 1'b1};  // straight to ACQUIRE
    vecs[5] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};

    #12;
    chk("reset_outs", 32'(obs), 32'(0));
    chk("reset_pcount", 32'(PeriodCount), 32'(0));
    @(posedge Clk); #1;
    Resetn = 1'b1;
    tick();
    chk("idle_after_reset", 32'(obs), 32'(0));

    for (int i = 0; i < 6; i++) begin
      Start = vecs[i].start; Abort = vecs[i].abort;
      SettleCycles = SW'(vecs[i].s); AcqCycles = AW'(vecs[i].a);
      tick();
      chk($sformatf("vec%0d_outs", i), 32'({CountEnable, AcqValid, Busy, Done}),
          32'({vecs[i].ce, vecs[i].av, vecs[i].busy, 1'b0}));
      Start = 1'b0; Abort = 1'b1;
      tick();
      chk($sformatf("vec%0d_abort", i), 32'(obs), 32'(0));
      Abort = 1'b0;
    end

    run_meas(3, 4, 8, 0, 0, 1'b0);
    run_meas(0, 2, 8, 3, 0, 1'b1);
    run_meas(2, 10, 8, 0, 3, 1'b0);   // abort in 2nd acquisition period
    run_meas(2, 10, 8, 5, 0, 1'b0);

    // Watchdog: IP never toggles after the Start is accepted
    Start = 1'b1; SettleCycles = SW'(1); AcqCycles = AW'(2);
    tick();
    Start = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("wdog_before", 32'(obs), 32'(7'b1010000));
    tick();
    chk("wdog_fire", 32'(obs), 32'(7'b0000001));
    tick();
    chk("wdog_sticky", 32'(obs), 32'(7'b0000001));
    run_meas(1, 3, 4, 1, 0, 1'b0);    // accepted Start clears Error

    // Asynchronous reset in the middle of acquisition
    Start = 1'b1; SettleCycles = SW'(0); AcqCycles = AW'(5);
    for (int n = 0; n < 10; n++) begin
      IP = (n % 4) >= 2;
      tick();
      Start = 1'b0;
    end
    chk("pre_reset_acq", 32'({AcqValid, Busy, PeriodCount}), 32'({1'b1, 1'b1, AW'(2)}));
    #2 Resetn = 1'b0;
    #1;
    chk("async_reset_outs", 32'(obs), 32'(0));
    chk("async_reset_pcount", 32'(PeriodCount), 32'(0));
    IP = 1'b0;
    tick();
    Resetn = 1'b1;
    tick(); tick();
    chk("post_reset_idle", 32'(obs), 32'(0));
    run_meas(1, 2, 4, 2, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      s  = $urandom_range(0, 4);
      a  = $urandom_range(1, 6);
      p  = 4 * $urandom_range(1, 3);
      ph = $urandom_range(0, p - 1);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ((s == 0) ? 1 : s) + a - 1) : 0;
      run_meas(s, a, p, ph, ak, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
